// File: rtl/regfile_bus_arbiter_pkg.sv
// Shared types and constants for the register-file bus arbiter.
// FSM encoding, default widths and the grant-index width helper.
package regfile_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_DATA_WIDTH = 32;

  // Index width for n requesters; never below one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/regfile_rr_picker.sv
// Combinational round-robin picker: rotate req by the pointer, take the
// lowest set bit, then rotate the index back into requester numbering.
module regfile_rr_picker
  import regfile_bus_arbiter_pkg::*;
#(
  parameter int N = DEF_NUM_REQ,
  localparam int W = id_width(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] pointer,
  output logic [W-1:0] winner,
  output logic         any_req
);

  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [W-1:0]   offset;
  logic [W:0]     sum;

  assign doubled = {req, req};
  assign rotated = doubled[pointer +: N];

  always_comb begin
    offset = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rotated[i]) offset = W'(i);
    end
  end

  assign sum     = {1'b0, pointer} + {1'b0, offset};
  assign winner  = (sum >= (W+1)'(N)) ? W'(sum - (W+1)'(N)) : sum[W-1:0];
  assign any_req = |req;

endmodule

// File: rtl/regfile_bus_arbiter.sv
// Round-robin arbiter sharing one register-file bus between NUM_REQ masters.
// Optional REGFILE_BUS_ARBITER_LOCK_EN adds req_lock to keep the grant for RMW.
//
// Handshake: a requester raises req with stable we/addr/wdata and holds it
// until its one-cycle ack; a req still high in the cycle after ack is a new
// transaction. Each grant runs IDLE -> ACCESS (one bus cycle) -> RESP (ack).
module regfile_bus_arbiter
  import regfile_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  localparam int ID_W      = id_width(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
`ifdef REGFILE_BUS_ARBITER_LOCK_EN
  input  logic [NUM_REQ-1:0]            req_lock,
`endif
  output logic [NUM_REQ-1:0]            ack,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic [ADDR_WIDTH-1:0]         addr,
  output logic                          chip_select,
  output logic                          write_en,
  output logic                          read_en,
  output logic [DATA_WIDTH-1:0]         write_data,
  input  logic [DATA_WIDTH-1:0]         read_data,
  input  logic                          data_valid,
  output logic [1:0]                    state_dbg
);

  state_t                state_q, state_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [ID_W-1:0]       winner, grant_d;
  logic                  any_req;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] wdata_d, rdata_d;
  logic                  cs_d, wen_d, ren_d, err_d;
  logic [NUM_REQ-1:0]    ack_d;

  regfile_rr_picker #(.N(NUM_REQ)) u_picker (
    .req     (req),
    .pointer (ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_id;
    addr_d  = addr;
    wdata_d = write_data;
    cs_d    = 1'b0;
    wen_d   = 1'b0;
    ren_d   = 1'b0;
    ack_d   = '0;
    rdata_d = rsp_rdata;
    err_d   = rsp_err;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          grant_d = winner;
          addr_d  = req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d = req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          cs_d    = 1'b1;
          wen_d   = req_we[winner];
          ren_d   = !req_we[winner];
        end
      end
      ACCESS: begin
        // write_en is registered and only high here, so it names the op type.
        state_d = RESP;
        ack_d[grant_id] = 1'b1;
        if (write_en) begin
          rdata_d = '0;
          err_d   = 1'b0;
        end else begin
          rdata_d = read_data;
          err_d   = !data_valid;
        end
      end
      RESP: begin
        state_d = IDLE;
        ptr_d   = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
`ifdef REGFILE_BUS_ARBITER_LOCK_EN
        if (req_lock[grant_id]) ptr_d = grant_id;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_id    <= '0;
      addr        <= '0;
      write_data  <= '0;
      chip_select <= 1'b0;
      write_en    <= 1'b0;
      read_en     <= 1'b0;
      ack         <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_id    <= grant_d;
      addr        <= addr_d;
      write_data  <= wdata_d;
      chip_select <= cs_d;
      write_en    <= wen_d;
      read_en     <= ren_d;
      ack         <= ack_d;
      rsp_rdata   <= rdata_d;
      rsp_err     <= err_d;
    end
  end

  assign busy      = (state_q == ACCESS) || (state_q == RESP);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_regfile_bus_arbiter.sv
// Self-checking bench for regfile_bus_arbiter: vector table, contention,
// lock/round-robin sequence and reset during a bus access.
module tb_regfile_bus_arbiter;

  localparam int NUM_REQ = 4;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int BUS_W   = 1 + AW + DW;
  localparam int RSP_W   = 2 + DW + 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_REQ-1:0]    req = '0;
  logic [NUM_REQ-1:0]    req_we = '0;
  logic [NUM_REQ*AW-1:0] req_addr = '0;
  logic [NUM_REQ*DW-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]    req_lock = '0;
  logic [NUM_REQ-1:0]    ack;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic [1:0]            grant_id;
  logic                  busy;
  logic [AW-1:0]         addr;
  logic                  chip_select, write_en, read_en;
  logic [DW-1:0]         write_data;
  logic [DW-1:0]         read_data;
  logic                  data_valid;
  logic [1:0]            state_dbg;
  logic                  dv = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cs_count = 0;
  logic [BUS_W-1:0] bus_q[$];
  logic [RSP_W-1:0] exp_q[$];
  int order_q[$];
  int remaining[NUM_REQ];

  typedef struct {
    int          id;
    logic        we;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        dv;
    logic [31:0] er;
    logic        ee;
  } vec_t;
  vec_t vecs[10];

  regfile_bus_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
`ifdef REGFILE_BUS_ARBITER_LOCK_EN
    .req_lock    (req_lock),
`endif
    .ack         (ack),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .grant_id    (grant_id),
    .busy        (busy),
    .addr        (addr),
    .chip_select (chip_select),
    .write_en    (write_en),
    .read_en     (read_en),
    .write_data  (write_data),
    .read_data   (read_data),
    .data_valid  (data_valid),
    .state_dbg   (state_dbg)
  );

  // Clock and reset-cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Register-file model: fixed contents, address 0x04 holds 3.
  function automatic logic [31:0] rf_val(input logic [7:0] a);
    return (a == 8'h04) ? 32'h0000_0003 : {a, ~a, a ^ 8'h5A, 8'h3C};
  endfunction

  assign read_data  = rf_val(addr);
  assign data_valid = dv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: bus accesses and acks are popped in order as the DUT shows them.
  always @(negedge clk) begin
    logic [BUS_W-1:0] b;
    logic [RSP_W-1:0] e;
    if (chip_select === 1'b1) begin
      cs_count++;
      if (bus_q.size() == 0) begin
        check("bus_unexpected", 1, 0);
      end else begin
        b = bus_q.pop_front();
        check("bus_write_en", write_en, b[BUS_W-1]);
        check("bus_read_en", read_en, !b[BUS_W-1]);
        check("bus_addr", addr, b[DW +: AW]);
        if (b[BUS_W-1]) check("bus_write_data", write_data, b[DW-1:0]);
      end
    end
    if ((|ack) === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("ack_unexpected", ack, 0);
      end else begin
        e = exp_q.pop_front();
        check("ack_onehot", ack, 4'b0001 << e[RSP_W-1 -: 2]);
        check("grant_id", grant_id, e[RSP_W-1 -: 2]);
        check("rsp_rdata", rsp_rdata, e[DW:1]);
        check("rsp_err", rsp_err, e[0]);
      end
    end
  end

  task automatic apply_vec(input vec_t v);
    int n;
    int cs0;
    req_addr[v.id*AW +: AW]  = v.a;
    req_wdata[v.id*DW +: DW] = v.wd;
    req_we[v.id]             = v.we;
    dv                       = v.dv;
    bus_q.push_back({v.we, v.a, v.wd});
    exp_q.push_back({2'(v.id), v.er, v.ee});
    cs0 = cs_count;
    req = '0;
    req[v.id] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_access", busy, 1);
    end while (!((|ack) === 1'b1) && n < 20);
    check("ack_latency", n, 2);
    check("cs_cycles", cs_count - cs0, 1);
    req = '0;
    @(negedge clk);
    check("rsp_hold_rdata", rsp_rdata, v.er);
    check("rsp_hold_err", rsp_err, v.ee);
    check("busy_idle", busy, 0);
  endtask

  // Requesters with remaining[] transactions each; all reads at 0x40+i.
  // keep[i]=1 leaves req high after ack (back-to-back transaction),
  // otherwise req drops for the RESP and following IDLE cycle.
  task automatic run_seq(input logic [NUM_REQ-1:0] keep);
    int n_exp, got, last, budget;
    logic [NUM_REQ-1:0] a, prev_a;
    dv = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_we[i] = 1'b0;
      req_addr[i*AW +: AW] = 8'h40 + 8'(i);
    end
    foreach (order_q[k]) begin
      bus_q.push_back({1'b0, 8'h40 + 8'(order_q[k]), 32'h0});
      exp_q.push_back({2'(order_q[k]), rf_val(8'h40 + 8'(order_q[k])), 1'b0});
    end
    n_exp = order_q.size();
    got = 0; last = -1; budget = 0; prev_a = '0;
    for (int i = 0; i < NUM_REQ; i++) req[i] = (remaining[i] > 0);
    while (got < n_exp && budget < 200) begin
      @(negedge clk);
      budget++;
      a = ack;
      if ((|a) === 1'b1) begin
        got++;
        if (last >= 0) check("ack_spacing", cyc - last, 3);
        last = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (a[i]) remaining[i]--;
      end
      for (int i = 0; i < NUM_REQ; i++)
        req[i] = (remaining[i] > 0) && !(a[i] === 1'b1 && !keep[i]) && !(prev_a[i] === 1'b1 && !keep[i]);
      prev_a = a;
    end
    if (got < n_exp) check("seq_timeout", got, n_exp);
    req = '0;
    order_q.delete();
  endtask

  initial begin
    vecs[0] = '{2, 1'b0, 8'h04, 32'h0,         1'b1, 32'h0000_0003, 1'b0};
    vecs[1] = '{1, 1'b1, 8'h1C, 32'hDEAD_BEEF, 1'b1, 32'h0,         1'b0};
    vecs[2] = '{0, 1'b0, 8'h30, 32'h0,         1'b0, rf_val(8'h30), 1'b1};
    vecs[3] = '{3, 1'b1, 8'h00, 32'h5555_AAAA, 1'b1, 32'h0,         1'b0};
    vecs[4] = '{3, 1'b0, 8'h80, 32'h0,         1'b1, rf_val(8'h80), 1'b0};
    vecs[5] = '{1, 1'b0, 8'hFF, 32'h0,         1'b1, rf_val(8'hFF), 1'b0};
    for (int i = 6; i < 10; i++) begin
      vecs[i].id = int'($urandom_range(0, NUM_REQ - 1));
      vecs[i].we = 1'b0;
      vecs[i].a  = 8'($urandom_range(0, 255));
      vecs[i].wd = $urandom;
      vecs[i].dv = 1'($urandom_range(0, 1));
      vecs[i].er = rf_val(vecs[i].a);
      vecs[i].ee = !vecs[i].dv;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_cs", chip_select, 0);
    check("rst_we", write_en, 0);
    check("rst_re", read_en, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", write_data, 0);
    check("rst_rdata", rsp_rdata, 0);
    check("rst_err", rsp_err, 0);
    check("rst_grant", grant_id, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // Contention straight out of reset: 0,1,2,3,0
    remaining = '{2, 1, 1, 1};
    order_q = '{0, 1, 2, 3, 0};
    run_seq('0);
    @(negedge clk);

    foreach (vecs[i]) apply_vec(vecs[i]);

    // Put the pointer at 3, then 3 runs two transactions against 0 and 1.
    apply_vec('{2, 1'b0, 8'h08, 32'h0, 1'b1, rf_val(8'h08), 1'b0});
    req_lock = 4'b1000;
    remaining = '{1, 1, 0, 2};
`ifdef REGFILE_BUS_ARBITER_LOCK_EN
    order_q = '{3, 3, 0, 1};
`else
    order_q = '{3, 0, 1, 3};
`endif
    run_seq(4'b1000);
    req_lock = '0;
    @(negedge clk);

    // Reset while the bus access is in flight
    req_we[2] = 1'b0;
    req_addr[2*AW +: AW] = 8'h10;
    bus_q.push_back({1'b0, 8'h10, 32'h0});
    req = 4'b0100;
    @(negedge clk);
    check("mid_cs_before_rst", chip_select, 1);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    check("mid_rst_cs", chip_select, 0);
    check("mid_rst_re", read_en, 0);
    check("mid_rst_ack", ack, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_state", state_dbg, 0);
    check("mid_rst_rdata", rsp_rdata, 0);
    check("mid_rst_grant", grant_id, 0);
    rst = 1'b0;
    remaining = '{2, 1, 1, 1};
    order_q = '{0, 1, 2, 3, 0};
    run_seq('0);

    repeat (5) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
